// File: rtl/match_collector.sv
// ---------------------------------------------------------------------------
// match_collector
//
// Back end of the CORDIC string-matching array. A start request opens a run:
// the block waits SETTLE clock edges for the rotation pipelines to converge,
// snapshots the per-index match flags, and then streams the legal match
// positions out lowest-first on a valid/ready channel. A total match count
// is published at capture time, and a one-cycle done pulse closes the run.
//
// Parameters
//   N       text length in bits (width of i_flag)
//   M       pattern length; only indices 0..N-M can be real matches
//   SETTLE  clock edges from start acceptance to flag capture (>= 1)
//   IDX_W   index width (>= clog2(N))
//
// Ports
//   i_clock        single clock, rising edge
//   i_reset        synchronous, active-low reset
//   i_start        begin a run (accepted only while idle)
//   i_flag         match vector, i_flag[i] = pattern matches at text index i
//   o_busy         high whenever a run is in progress (including done cycle)
//   o_idx_valid    o_idx_data holds a match index
//   i_idx_ready    consumer accepts the index when valid & ready
//   o_idx_data     matched text index
//   o_match_count  number of legal matches captured in current/last run
//   o_done         one-cycle pulse marking the end of a run
// ---------------------------------------------------------------------------
module match_collector #(
    parameter int N      = 16,
    parameter int M      = 4,
    parameter int SETTLE = 32,
    parameter int IDX_W  = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [0:N-1]     i_flag,
    output logic             o_busy,
    output logic             o_idx_valid,
    input  logic             i_idx_ready,
    output logic [IDX_W-1:0] o_idx_data,
    output logic [IDX_W:0]   o_match_count,
    output logic             o_done
);

    // Settle counter only has to reach SETTLE-1.
    localparam int CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW       = IDX_W + 1;
    localparam int LAST_IDX = N - M;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_pend;       // bit i = index i still to be emitted
    logic [IDX_W:0]   r_match_count;

    logic [N-1:0]     w_legal_flag;
    logic [CW-1:0]    w_pop;
    logic [IDX_W-1:0] w_low_idx;
    logic [N-1:0]     w_low_oh;
    logic [N-1:0]     w_pend_next;
    logic             w_valid;
    logic             w_hs;

    // Indices past N-M would need text bits beyond the end of the string;
    // whatever the array reports there is not a match.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        if (gi <= LAST_IDX) begin : g_legal
            assign w_legal_flag[gi] = i_flag[gi];
        end else begin : g_tail
            assign w_legal_flag[gi] = 1'b0;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + CW'(w_legal_flag[i]);
        end
    end

    // Lowest set bit of the pending vector: scan downwards so the last hit
    // written is the lowest index.
    always_comb begin
        w_low_idx = '0;
        w_low_oh  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx   = IDX_W'(i);
                w_low_oh    = '0;
                w_low_oh[i] = 1'b1;
            end
        end
    end

    assign w_valid     = (r_state == S_EMIT) && (r_pend != '0);
    assign w_hs        = w_valid && i_idx_ready;
    assign w_pend_next = r_pend & ~w_low_oh;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pend        <= '0;
            r_match_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt         <= '0;
                        r_match_count <= '0;
                        r_state       <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_pend        <= w_legal_flag;
                        r_match_count <= w_pop;
                        r_cnt         <= '0;
                        r_state       <= S_EMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (r_pend == '0) begin
                        r_state <= S_DONE;
                    end else if (w_hs) begin
                        r_pend <= w_pend_next;
                        if (w_pend_next == '0) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_idx_valid   = w_valid;
    assign o_idx_data    = w_valid ? w_low_idx : '0;
    assign o_match_count = r_match_count;
    assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_match_collector.sv
module tb_match_collector;

    localparam int N      = 16;
    localparam int M      = 4;
    localparam int SETTLE = 32;
    localparam int IDX_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [0:N-1]     flag;
    logic             busy;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx_data;
    logic [IDX_W:0]   match_count;
    logic             done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    match_collector #(.N(N), .M(M), .SETTLE(SETTLE), .IDX_W(IDX_W)) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_flag        (flag),
        .o_busy        (busy),
        .o_idx_valid   (idx_valid),
        .i_idx_ready   (idx_ready),
        .o_idx_data    (idx_data),
        .o_match_count (match_count),
        .o_done        (done)
    );

    // Advance one edge; everything after this sits 1 ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept start at E0, then walk through the settle window up to and
    // including the capture edge E32. Returns in cycle 33.
    task automatic run_to_emit(input logic [0:N-1] f, input string tag);
        flag  = f;
        start = 1'b1;
        step();                       // E0
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        for (int k = 1; k < SETTLE; k++) begin
            chk({tag, "_settle_valid"}, idx_valid, 0);
            chk({tag, "_settle_done"}, done, 0);
            step();                   // E1 .. E31
        end
        chk({tag, "_pre_capture_valid"}, idx_valid, 0);
        step();                       // E32: capture
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b1;
        flag      = '1;
        idx_ready = 1'b1;

        // --- reset held for 3 edges with start and all flags asserted
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", idx_valid, 0);
        chk("rst_data", idx_data, 0);
        chk("rst_done", done, 0);
        chk("rst_count", match_count, 0);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // --- two matches at indices 0 and 10, ready held high
        run_to_emit(16'b1000_0000_0010_0000, "two");
        chk("two_c33_valid", idx_valid, 1);
        chk("two_c33_data", idx_data, 0);
        chk("two_c33_count", match_count, 2);
        step();
        chk("two_c34_valid", idx_valid, 1);
        chk("two_c34_data", idx_data, 10);
        step();
        chk("two_c35_done", done, 1);
        chk("two_c35_valid", idx_valid, 0);
        chk("two_c35_busy", busy, 1);
        chk("two_c35_count", match_count, 2);
        step();
        chk("two_c36_done", done, 0);
        chk("two_c36_busy", busy, 0);
        chk("two_c36_count_hold", match_count, 2);

        // --- backpressure: ready low for the first 5 EMIT cycles
        idx_ready = 1'b0;
        run_to_emit(16'b1000_0000_0010_0000, "bp");
        for (int k = 0; k < 5; k++) begin
            chk("bp_stall_valid", idx_valid, 1);
            chk("bp_stall_data", idx_data, 0);
            chk("bp_stall_done", done, 0);
            step();
        end
        idx_ready = 1'b1;
        chk("bp_first_data", idx_data, 0);
        chk("bp_first_valid", idx_valid, 1);
        step();
        chk("bp_second_data", idx_data, 10);
        chk("bp_second_done", done, 0);
        step();
        chk("bp_done", done, 1);
        chk("bp_count", match_count, 2);
        step();

        // --- only masked tail positions 13..15 set
        run_to_emit(16'b0000_0000_0000_0111, "mask");
        chk("mask_c33_valid", idx_valid, 0);
        chk("mask_c33_done", done, 0);
        chk("mask_c33_busy", busy, 1);
        step();
        chk("mask_c34_done", done, 1);
        chk("mask_c34_valid", idx_valid, 0);
        chk("mask_count", match_count, 0);
        step();
        chk("mask_c35_done", done, 0);

        // --- capture isolation: indices 2 and 12 (last legal) captured,
        //     flags then flood to ones and start pulses during EMIT / DONE
        run_to_emit(16'b0010_0000_0000_1000, "iso");
        flag  = '1;
        start = 1'b1;
        chk("iso_c33_data", idx_data, 2);
        chk("iso_c33_count", match_count, 2);
        step();
        chk("iso_c34_data", idx_data, 12);
        chk("iso_c34_valid", idx_valid, 1);
        step();
        chk("iso_c35_done", done, 1);
        chk("iso_c35_count", match_count, 2);
        step();                       // start still high during DONE
        chk("iso_c36_busy", busy, 0);
        chk("iso_c36_count", match_count, 2);
        start = 1'b0;
        step();
        chk("iso_c37_busy", busy, 0);

        // --- reset mid-EMIT after the first handshake
        run_to_emit(16'b1000_0000_0010_0000, "mrst");
        chk("mrst_c33_data", idx_data, 0);
        step();                       // handshake on index 0
        chk("mrst_c34_data", idx_data, 10);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", idx_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_data", idx_data, 0);
        chk("mrst_count", match_count, 0);
        rst_n = 1'b1;
        step();
        chk("mrst_no_done", done, 0);

        // --- normal run after the mid-run reset: single match at index 5
        run_to_emit(16'b0000_0100_0000_0000, "post");
        chk("post_c33_data", idx_data, 5);
        chk("post_c33_valid", idx_valid, 1);
        chk("post_count", match_count, 1);
        step();
        chk("post_c34_done", done, 1);
        chk("post_c34_valid", idx_valid, 0);
        step();
        chk("post_c35_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
